alu_frame_rx: RTL and testbench
===============================

# alu_frame_rx

Deserialising receiver for the 56-bit ALU state frame emitted by the ALU demo top level over the S_CLK / S_DATA / S_RESET shift link. It synchronises the three link wires into the CLK domain, reassembles each frame LSB-first, validates framing, and presents the decoded x, y, out and control/flag fields with a one-cycle valid strobe. It sits directly downstream of the shift-out logic and feeds display/logging logic.

## Interface
- SYNC_STAGES, 2: flip-flop synchroniser depth on each link input (≥2).
- TIMEOUT_CYCLES, 12000: CLK cycles without an S_CLK rising edge in SHIFT before the frame is aborted.
- CLK  in  1  system clock (12 MHz nominal); sole clock.
- RST_N  in  1  reset, asynchronous, active-low.
- S_CLK, S_DATA, S_RESET  in  1 each  link wires, asynchronous to CLK.
- x, y, out  out  16 each  decoded ALU operands and result.
- zx, nx, zy, ny, f, no, ng, zr  out  1 each  decoded control bits and flags.
- frame_valid  out  1  one-cycle pulse: fields just updated.
- frame_err  out  1  one-cycle pulse: frame discarded.
- frame_count  out  8  count of valid frames, wraps 255→0.
- check_fail  out  1  see Configuration.

## Operation
- Frame order on wire, first bit first: zr, ng, no, f, ny, zy, nx, zx, out[0..15], y[0..15], x[0..15]. 56 bits total.
- Sender changes S_DATA on S_CLK falling edge; receiver samples synchronised S_DATA on synchronised S_CLK rising edge.
- S_RESET high marks frame boundary; frame bits only while S_RESET low.
- FSM, reset state HUNT:
  - HUNT: ignore S_CLK; on S_RESET sync'd high → ARM.
  - ARM: bit counter cleared, S_CLK edges ignored; on S_RESET low → SHIFT.
  - SHIFT: each S_CLK rise shifts bit into 56-bit register (right shift, new bit at MSB), counter +1, saturating at 57. On S_RESET rise: count==56 → latch fields, frame_valid, frame_count+1, → ARM; otherwise frame_err, fields hold, → ARM. Idle timer reaching TIMEOUT_CYCLES → frame_err, → HUNT.
- Simultaneous S_CLK rise and S_RESET rise detected in same cycle: S_RESET wins, bit discarded.
- frame_valid and frame_err never both high.
- Reset mid-frame: all state cleared, partial frame discarded, → HUNT.

## Timing
- Reset values: all field outputs 0, frame_valid 0, frame_err 0, frame_count 0, check_fail 0.
- Edge detect latency: SYNC_STAGES+1 CLK cycles from first CLK edge sampling link change.
- frame_valid/frame_err assert SYNC_STAGES+2 cycles after S_RESET rise is first sampled; fields, frame_count and check_fail valid in the same cycle and held until next valid frame.
- CLK must be ≥8× S_CLK frequency; link high/low phases ≥ SYNC_STAGES+2 CLK cycles.
- Idle timer resets on every S_CLK rise and on SHIFT entry.

## Configuration
- ALU_FRAME_CHECK_EN defined: combinational Hack-ALU model recomputes result from received x, y, zx..no (zero, negate inputs; f ? add mod 2^16 : AND; no ? invert); check_fail registered with fields, high when recomputed result ≠ out, zr ≠ (result==0), or ng ≠ result[15].
- Undefined: no model; check_fail tied 0.

## Test plan
- Reset, S_RESET pulse, frame x=0x1234, y=0x0000, zx=0 nx=1 zy=1 ny=1 f=1 no=1, out=0x1235, ng=0 zr=0, S_RESET high -> one frame_valid pulse, fields match, frame_count=1, check_fail=0.
- Release reset mid-stream: 20 bits, S_RESET high, full frame -> first boundary gives no pulse; second gives frame_valid, frame_count=1.
- 55-bit frame then 57-bit frame -> frame_err pulse each, fields and frame_count unchanged.
- S_CLK stalls after 30 bits for TIMEOUT_CYCLES+10 -> frame_err, HUNT; next S_RESET then 56-bit frame -> frame_valid.
- 256 valid frames -> frame_count wraps to 0; RST_N low mid-frame -> all outputs 0 immediately.
- ALU_FRAME_CHECK_EN: x=0x1234, out=0x1236 (x+1 controls) -> frame_valid with check_fail=1; x=0xFFFF, out=0x0000, zr=1 -> check_fail=0.

Source files
------------

// File: rtl/alu_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : alu_frame_rx
//  Purpose  : Deserialising receiver for the 56-bit ALU state frame carried
//             on the S_CLK / S_DATA / S_RESET shift link. Synchronises the
//             link into the CLK domain, reassembles frames LSB-first,
//             validates framing and presents decoded fields with a strobe.
//  Options  : ALU_FRAME_CHECK_EN - when defined, a Hack-ALU model recomputes
//             the result from the received operands/controls and drives
//             check_fail; otherwise check_fail is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_frame_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 12000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        S_CLK,
   input  logic        S_DATA,
   input  logic        S_RESET,
   output logic [15:0] x,
   output logic [15:0] y,
   output logic [15:0] out,
   output logic        zx,
   output logic        nx,
   output logic        zy,
   output logic        ny,
   output logic        f,
   output logic        no,
   output logic        ng,
   output logic        zr,
   output logic        frame_valid,
   output logic        frame_err,
   output logic [7:0]  frame_count,
   output logic        check_fail
);

   localparam int         TW        = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [5:0] FRAME_BITS = 6'd56;
   localparam logic [5:0] CNT_SAT    = 6'd57;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      ARM   = 2'd1,
      SHIFT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SYNC_STAGES-1:0] sclk_sync, sdata_sync, srst_sync;
   logic                   sclk_d, srst_d;
   logic                   sclk_rise, srst_rise, data_smp;
   logic                   srst_lvl;

   logic [55:0]   sr;
   logic [5:0]    bit_cnt;
   logic [TW-1:0] idle;

   logic do_shift, do_latch, do_err;
   logic mism;

   assign srst_lvl = srst_sync[SYNC_STAGES-1];

   // Multi-flop synchronisers for the three asynchronous link wires
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sclk_sync  <= '0;
         sdata_sync <= '0;
         srst_sync  <= '0;
      end else begin
         sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], S_CLK};
         sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], S_DATA};
         srst_sync  <= {srst_sync[SYNC_STAGES-2:0], S_RESET};
      end
   end

   // Registered rising-edge detection; data captured alongside the S_CLK edge
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sclk_d    <= 1'b0;
         srst_d    <= 1'b0;
         sclk_rise <= 1'b0;
         srst_rise <= 1'b0;
         data_smp  <= 1'b0;
      end else begin
         sclk_d    <= sclk_sync[SYNC_STAGES-1];
         srst_d    <= srst_sync[SYNC_STAGES-1];
         sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_d;
         srst_rise <= srst_sync[SYNC_STAGES-1] & ~srst_d;
         data_smp  <= sdata_sync[SYNC_STAGES-1];
      end
   end

   // FSM state register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= HUNT;
      else        state <= state_nxt;
   end

   // FSM next state and datapath strobes; a boundary outranks a coincident bit
   always_comb begin
      state_nxt = state;
      do_shift  = 1'b0;
      do_latch  = 1'b0;
      do_err    = 1'b0;
      case (state)
         HUNT: begin
            if (srst_lvl) state_nxt = ARM;
         end
         ARM: begin
            if (!srst_lvl) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (srst_rise) begin
               state_nxt = ARM;
               if (bit_cnt == FRAME_BITS) do_latch = 1'b1;
               else                       do_err   = 1'b1;
            end else if (sclk_rise) begin
               do_shift = 1'b1;
            end else if (idle == IDLE_LAST) begin
               do_err    = 1'b1;
               state_nxt = HUNT;
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   // Shift register, saturating bit counter and idle timer
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sr      <= '0;
         bit_cnt <= '0;
         idle    <= '0;
      end else if (state != SHIFT) begin
         bit_cnt <= '0;
         idle    <= '0;
      end else if (do_shift) begin
         sr   <= {data_smp, sr[55:1]};
         idle <= '0;
         if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 6'd1;
      end else begin
         idle <= idle + TW'(1);
      end
   end

   // Field latch, strobes and frame counter
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         frame_count <= '0;
         x   <= '0;
         y   <= '0;
         out <= '0;
         {zx, nx, zy, ny, f, no, ng, zr} <= '0;
      end else begin
         frame_valid <= do_latch;
         frame_err   <= do_err;
         if (do_latch) begin
            frame_count <= frame_count + 8'd1;
            x   <= sr[55:40];
            y   <= sr[39:24];
            out <= sr[23:8];
            {zx, nx, zy, ny, f, no, ng, zr} <= sr[7:0];
         end
      end
   end

`ifdef ALU_FRAME_CHECK_EN
   logic [15:0] ax, ay, ares;

   // Hack-ALU reference computed from the frame currently in the shift register
   always_comb begin
      ax = sr[7] ? 16'h0000 : sr[55:40];
      if (sr[6]) ax = ~ax;
      ay = sr[5] ? 16'h0000 : sr[39:24];
      if (sr[4]) ay = ~ay;
      ares = sr[3] ? (ax + ay) : (ax & ay);
      if (sr[2]) ares = ~ares;
      mism = (ares != sr[23:8]) || (sr[0] != (ares == 16'h0000)) || (sr[1] != ares[15]);
   end

   // check_fail updates together with the latched fields
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)        check_fail <= 1'b0;
      else if (do_latch) check_fail <= mism;
   end
`else
   assign mism       = 1'b0;
   assign check_fail = mism;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_frame_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_frame_rx
//  Purpose  : Directed self-checking bench for alu_frame_rx.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_frame_rx;

   localparam int TIMEOUT = 300;
`ifdef ALU_FRAME_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic        CLK = 1'b0;
   logic        RST_N, S_CLK, S_DATA, S_RESET;
   logic [15:0] x, y, out;
   logic        zx, nx, zy, ny, f, no, ng, zr;
   logic        frame_valid, frame_err, check_fail;
   logic [7:0]  frame_count;

   int tests  = 0;
   int failed = 0;
   int ph     = 4;

   alu_frame_rx #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .CLK(CLK), .RST_N(RST_N), .S_CLK(S_CLK), .S_DATA(S_DATA), .S_RESET(S_RESET),
      .x(x), .y(y), .out(out),
      .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no), .ng(ng), .zr(zr),
      .frame_valid(frame_valid), .frame_err(frame_err),
      .frame_count(frame_count), .check_fail(check_fail)
   );

   always #5 CLK = ~CLK;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   // Wire order: zr first, x[15] last
   function automatic logic [63:0] mk(input logic [15:0] fx, input logic [15:0] fy,
                                      input logic [15:0] fo, input logic [7:0] fl);
      return {8'h00, fx, fy, fo, fl};
   endfunction

   task automatic send_bits(input logic [63:0] bits, input int n);
      for (int i = 0; i < n; i++) begin
         S_CLK  = 1'b0;
         S_DATA = bits[i];
         cyc(ph);
         S_CLK = 1'b1;
         cyc(ph);
      end
      S_CLK = 1'b0;
      cyc(ph);
   endtask

   task automatic boundary(input string tag, input int ev, input int ee);
      int nv, ne, both;
      nv = 0; ne = 0; both = 0;
      S_RESET = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc(1);
         if (frame_valid) nv++;
         if (frame_err) ne++;
         if (frame_valid && frame_err) both++;
      end
      S_RESET = 1'b0;
      cyc(6);
      check_eq({tag, "_valid"}, 64'(nv), 64'(ev));
      check_eq({tag, "_err"}, 64'(ne), 64'(ee));
      check_eq({tag, "_both"}, 64'(both), 64'd0);
   endtask

   task automatic chk_fields(input string tag, input logic [15:0] ex, input logic [15:0] ey,
                             input logic [15:0] eo, input logic [7:0] efl);
      check_eq({tag, "_x"}, 64'(x), 64'(ex));
      check_eq({tag, "_y"}, 64'(y), 64'(ey));
      check_eq({tag, "_out"}, 64'(out), 64'(eo));
      check_eq({tag, "_flags"}, 64'({zx, nx, zy, ny, f, no, ng, zr}), 64'(efl));
   endtask

   initial begin
      logic [63:0] fa, fb, fc;
      int ne, nv;
      // controls zx=0 nx=1 zy=1 ny=1 f=1 no=1 compute x+1
      fa = mk(16'h1234, 16'h0000, 16'h1235, 8'h7C);
      fb = mk(16'hFFFF, 16'h0000, 16'h0000, 8'h7D);
      fc = mk(16'h1234, 16'h0000, 16'h1236, 8'h7C);

      RST_N = 1'b0; S_CLK = 1'b0; S_DATA = 1'b0; S_RESET = 1'b0;
      cyc(3);
      chk_fields("rst", 16'h0, 16'h0, 16'h0, 8'h00);
      check_eq("rst_valid", 64'(frame_valid), 64'd0);
      check_eq("rst_err", 64'(frame_err), 64'd0);
      check_eq("rst_count", 64'(frame_count), 64'd0);
      check_eq("rst_chk", 64'(check_fail), 64'd0);
      RST_N = 1'b1;
      cyc(2);

      // Mid-stream start: the first boundary only arms the receiver
      send_bits(fb, 20);
      boundary("hunt", 0, 0);
      send_bits(fa, 56);
      boundary("fa", 1, 0);
      chk_fields("fa", 16'h1234, 16'h0000, 16'h1235, 8'h7C);
      check_eq("fa_count", 64'(frame_count), 64'd1);
      check_eq("fa_chk", 64'(check_fail), 64'd0);

      // Short and long frames are discarded
      send_bits(fb, 55);
      boundary("b55", 0, 1);
      chk_fields("b55", 16'h1234, 16'h0000, 16'h1235, 8'h7C);
      check_eq("b55_count", 64'(frame_count), 64'd1);
      send_bits({8'h01, fb[55:0]}, 57);
      boundary("b57", 0, 1);
      chk_fields("b57", 16'h1234, 16'h0000, 16'h1235, 8'h7C);
      check_eq("b57_count", 64'(frame_count), 64'd1);

      // S_CLK stall aborts the frame
      send_bits(fb, 30);
      ne = 0; nv = 0;
      for (int i = 0; i < TIMEOUT + 10; i++) begin
         cyc(1);
         if (frame_err) ne++;
         if (frame_valid) nv++;
      end
      check_eq("tmo_err", 64'(ne), 64'd1);
      check_eq("tmo_valid", 64'(nv), 64'd0);
      boundary("tmo_arm", 0, 0);
      send_bits(fb, 56);
      boundary("fb", 1, 0);
      chk_fields("fb", 16'hFFFF, 16'h0000, 16'h0000, 8'h7D);
      check_eq("fb_count", 64'(frame_count), 64'd2);
      check_eq("fb_chk", 64'(check_fail), 64'd0);

      send_bits(fc, 56);
      boundary("fc", 1, 0);
      chk_fields("fc", 16'h1234, 16'h0000, 16'h1236, 8'h7C);
      check_eq("fc_count", 64'(frame_count), 64'd3);
      check_eq("fc_chk", 64'(check_fail), 64'(CHK));

      // Counter wrap, using a faster link to keep the run short
      ph = 2;
      for (int k = 0; k < 252; k++) begin
         send_bits(fa, 56);
         S_RESET = 1'b1;
         cyc(8);
         S_RESET = 1'b0;
         cyc(6);
      end
      check_eq("cnt_255", 64'(frame_count), 64'd255);
      check_eq("wrap_chk", 64'(check_fail), 64'd0);
      send_bits(fa, 56);
      boundary("wrap", 1, 0);
      check_eq("cnt_wrap", 64'(frame_count), 64'd0);
      ph = 4;

      send_bits(fb, 56);
      boundary("fd", 1, 0);
      check_eq("fd_count", 64'(frame_count), 64'd1);

      // Asynchronous reset mid-frame clears outputs at once
      send_bits(fa, 20);
      RST_N = 1'b0;
      #2;
      chk_fields("arst", 16'h0, 16'h0, 16'h0, 8'h00);
      check_eq("arst_count", 64'(frame_count), 64'd0);
      check_eq("arst_valid", 64'(frame_valid), 64'd0);
      check_eq("arst_err", 64'(frame_err), 64'd0);
      check_eq("arst_chk", 64'(check_fail), 64'd0);
      cyc(3);
      RST_N = 1'b1;
      cyc(2);
      boundary("rearm", 0, 0);
      send_bits(fa, 56);
      boundary("fe", 1, 0);
      check_eq("fe_count", 64'(frame_count), 64'd1);
      chk_fields("fe", 16'h1234, 16'h0000, 16'h1235, 8'h7C);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
